// File: rtl/rr_arb_mux_8.sv
// Eight-way round-robin arbiter driving an 8:1 single-bit data mux.
// Grants are held for at most HOLD_MAX cycles, and a release hands over to the next winner on the same edge.
module rr_arb_mux_8 #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] din,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       q,
    output logic       q_valid
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [3:0] HOLD = 4'(HOLD_MAX);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nxt;
    logic [2:0] r_sel;
    logic [2:0] w_sel_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [7:0] r_gnt;
    logic [7:0] w_gnt_nxt;
    logic       r_q;
    logic       r_qv;
    logic [2:0] w_win;
    logic       w_found;
    logic       w_hold;

    // First set request at or after r_ptr, wrapping 7 -> 0.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int i = 0; i < 8; i++) begin
            if (!w_found && req[3'(r_ptr + 3'(i))]) begin
                w_found = 1'b1;
                w_win   = 3'(r_ptr + 3'(i));
            end
        end
    end

    assign w_hold = (r_state == GRANT) && req[r_sel] && (r_cnt < HOLD);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        if (w_hold) begin
            w_cnt_nxt = r_cnt + 4'd1;
        end else if (w_found) begin
            w_state_nxt = GRANT;
            w_gnt_nxt   = 8'd1 << w_win;
            w_sel_nxt   = w_win;
            w_ptr_nxt   = w_win + 3'd1;
            w_cnt_nxt   = 4'd1;
        end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = 8'd0;
            w_cnt_nxt   = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= 3'd0;
            r_sel   <= 3'd0;
            r_cnt   <= 4'd0;
            r_gnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    // Data path trails the grant by one cycle; q is frozen while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q  <= 1'b0;
            r_qv <= 1'b0;
        end else begin
            if (r_gnt != 8'd0) begin
                r_q <= din[r_sel];
            end
            r_qv <= (r_gnt != 8'd0);
        end
    end

    assign gnt     = r_gnt;
    assign sel     = r_sel;
    assign q       = r_q;
    assign q_valid = r_qv;

endmodule

// File: tb/tb_rr_arb_mux_8.sv
// Directed vector table plus reset, full-load rotation and random-traffic
// property sequences for rr_arb_mux_8 with HOLD_MAX=4.
module tb_rr_arb_mux_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       q;
    logic       q_valid;

    int n_err;
    int n_chk;

    rr_arb_mux_8 #(.HOLD_MAX(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .din    (din),
        .gnt    (gnt),
        .sel    (sel),
        .q      (q),
        .q_valid(q_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic [7:0] din;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       q;
        logic       qv;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic step(input logic [7:0] r, input logic [7:0] d);
        req = r;
        din = d;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] rprev;
    logic [7:0] dprev;
    logic [7:0] g_rec;
    logic [2:0] s_rec;
    logic       exp_q;
    logic [7:0] rnd_req;
    int         wt[8];
    int         wmax;
    int         exp_idx;

    initial begin
        n_err = 0;
        n_chk = 0;
        rst_n = 1'b0;
        req   = 8'h00;
        din   = 8'h00;

        // req, din -> gnt, sel, q, q_valid after the next edge
        vt[0]  = '{8'h04, 8'h04, 8'h04, 3'd2, 1'b0, 1'b0};
        vt[1]  = '{8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1};
        vt[2]  = '{8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1};
        vt[3]  = '{8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1};
        vt[4]  = '{8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1};
        vt[5]  = '{8'h04, 8'h00, 8'h04, 3'd2, 1'b0, 1'b1};
        vt[6]  = '{8'h0C, 8'h08, 8'h04, 3'd2, 1'b0, 1'b1};
        vt[7]  = '{8'h08, 8'h08, 8'h08, 3'd3, 1'b0, 1'b1};
        vt[8]  = '{8'h02, 8'h08, 8'h02, 3'd1, 1'b1, 1'b1};
        vt[9]  = '{8'h00, 8'h00, 8'h00, 3'd1, 1'b0, 1'b1};
        vt[10] = '{8'h00, 8'hFF, 8'h00, 3'd1, 1'b0, 1'b0};
        vt[11] = '{8'h81, 8'h01, 8'h80, 3'd7, 1'b0, 1'b0};
        vt[12] = '{8'h81, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1};

        #2;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_qv", 32'(q_valid), 32'h0);
        #10;
        rst_n = 1'b1;

        for (int v = 0; v < 13; v++) begin
            step(vt[v].req, vt[v].din);
            chk($sformatf("v%0d_gnt", v), 32'(gnt), 32'(vt[v].gnt));
            chk($sformatf("v%0d_sel", v), 32'(sel), 32'(vt[v].sel));
            chk($sformatf("v%0d_q", v), 32'(q), 32'(vt[v].q));
            chk($sformatf("v%0d_qv", v), 32'(q_valid), 32'(vt[v].qv));
        end

        // Asynchronous reset between edges while index 7 is granted.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'h0);
        chk("arst_sel", 32'(sel), 32'h0);
        chk("arst_q", 32'(q), 32'h0);
        chk("arst_qv", 32'(q_valid), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(8'h81, 8'h00);
        chk("arst_win_gnt", 32'(gnt), 32'h01);
        chk("arst_win_sel", 32'(sel), 32'h0);

        // Full load: each index granted for four cycles in turn.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 36; k++) begin
            step(8'hFF, 8'h00);
            exp_idx = (k / 4) % 8;
            chk($sformatf("rot%0d_gnt", k), 32'(gnt), 32'(8'd1 << exp_idx));
            chk($sformatf("rot%0d_sel", k), 32'(sel), 32'(exp_idx));
        end

        // Random traffic with sticky request bits.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        g_rec   = 8'h00;
        s_rec   = 3'd0;
        exp_q   = 1'b0;
        rnd_req = 8'h00;
        for (int i = 0; i < 8; i++) wt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(15) == 0) rnd_req[b] = ~rnd_req[b];
            end
            rprev = rnd_req;
            dprev = 8'($urandom);
            step(rprev, dprev);
            chk("rnd_onehot", 32'($onehot0(gnt) && (gnt == 8'h00 || gnt[sel])),
                32'h1);
            if (g_rec != 8'h00) exp_q = dprev[s_rec];
            chk("rnd_q", 32'(q), 32'(exp_q));
            chk("rnd_qv", 32'(q_valid), 32'(g_rec != 8'h00));
            wmax = 0;
            for (int i = 0; i < 8; i++) begin
                if (rprev[i] && !gnt[i]) wt[i]++;
                else wt[i] = 0;
                if (wt[i] > wmax) wmax = wt[i];
            end
            chk("rnd_starve", 32'(wmax <= 28), 32'h1);
            g_rec = gnt;
            s_rec = sel;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux_8.md
RR_ARB_MUX_8 -- requirements
Module: rr_arb_mux_8

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 4, meaning the maximum consecutive grant cycles per requester (legal range 1-15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 8 bits: request per requester; bit i belongs to data input D(i+1).
REQ-005 The block SHALL have port din, input, 8 bits: data bits D1..D8 as din[0]..din[7].
REQ-006 The block SHALL have port gnt, output, 8 bits: one-hot grant, registered.
REQ-007 The block SHALL have port sel, output, 3 bits: index of the granted requester, registered; it drives the 8:1 datapath select.
REQ-008 The block SHALL have port q, output, 1 bit: registered selected data.
REQ-009 The block SHALL have port q_valid, output, 1 bit: q holds valid granted data.

Function
REQ-010 The FSM SHALL have two states: IDLE (gnt=0) and GRANT (exactly one gnt bit set).
REQ-011 Arbitration SHALL be round-robin: search starts at index ptr, ascending, wrapping 7->0; the first set req bit wins.
REQ-012 ptr SHALL be 0 after reset; on each new grant, ptr SHALL become (winner+1) mod 8.
REQ-013 In IDLE with req!=0, the next edge SHALL enter GRANT: gnt=onehot(winner), sel=winner, hold counter cnt=1.
REQ-014 In IDLE with req==0, the block SHALL stay in IDLE with gnt=0 and sel holding its last value.
REQ-015 In GRANT, when req[sel]=1 and cnt<HOLD_MAX, the grant SHALL hold and cnt SHALL increment.
REQ-016 In GRANT, when req[sel]=0 or cnt==HOLD_MAX, the grant SHALL be released at the next edge.
REQ-017 On release with any req bit set, the next winner SHALL be granted at that same edge (no idle gap), with cnt=1.
REQ-018 On release with req==0, the block SHALL enter IDLE.
REQ-019 A sole requester at cnt==HOLD_MAX SHALL be re-granted (search wraps back to it), with cnt=1 and no gap cycle.
REQ-020 q SHALL equal din[sel] sampled at an edge where gnt!=0, and q_valid SHALL equal (gnt!=0) at that edge; both appear 1 cycle after the grant cycle.
REQ-021 When no grant is active, q SHALL hold its last value and q_valid SHALL be 0.
REQ-022 gnt SHALL never have more than one bit set, and gnt[sel] SHALL be 1 whenever gnt!=0.
REQ-023 Requests that change mid-grant SHALL NOT affect the current grant except via REQ-016.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for clk, force: gnt=0, sel=0, q=0, q_valid=0, ptr=0, cnt=0, state=IDLE.
REQ-025 Reset asserted mid-grant SHALL abort the grant; after release, arbitration SHALL restart from ptr=0.
REQ-026 The first edge after rst_n rises SHALL evaluate as IDLE.

Verification
REQ-027 Reset then req=8'hFF held, HOLD_MAX=4 -> grants go 0,1,...,7,0, four cycles each, sel tracking, no gap cycles.
REQ-028 req=8'b0000_0100, din=8'b0000_0100 -> gnt=8'h04 and sel=2 after 1 edge; q=1 and q_valid=1 one edge later; regrant every 4 cycles.
REQ-029 While 3 is granted, drop req[3] and hold req[1]=1 -> next edge gnt=8'h02 (wrap past 7), cnt=1.
REQ-030 Drop all req during a grant -> next edge IDLE with gnt=0; one edge later q_valid=0 and q holds its value.
REQ-031 Assert rst_n=0 mid-grant, between clock edges -> gnt, sel, q and q_valid are 0 immediately; with req=8'h81 after release, index 0 wins first.
REQ-032 Random req/din for 10k cycles -> gnt one-hot or zero every cycle, q matches din[sel] delayed one cycle, and no requester with req held starves more than 7*HOLD_MAX cycles.
